// File: rtl/turn_controller_pkg.sv
// rtl/turn_controller_pkg.sv - shared game types and widths for the turn controller
package turn_controller_pkg;

    localparam int NUM_TILES_DEF = 12;
    localparam int TILE_W        = 4;
    localparam int COMBO_W       = 4;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CHECK,
        ST_REVEAL,
        ST_MOVE,
        ST_ENDTURN,
        ST_WIN
    } state_t;

endpackage

// File: rtl/reveal_timer.sv
// rtl/reveal_timer.sv - loadable down-counter; done marks the last cycle of a CYCLES-long window
module reveal_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - turn sequencing FSM driving the board data-path handshake
module turn_controller
    import turn_controller_pkg::*;
#(
    parameter int NUM_TILES     = NUM_TILES_DEF,
    parameter int RESP_LAT      = 1,
    parameter int REVEAL_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sel_valid,
    input  logic [TILE_W-1:0]     sel_tile,
    input  logic                  go,
    input  logic                  W,
    output logic                  A,
    output logic [TILE_W-1:0]     position_data,
    output logic                  B,
    output logic                  statecombo_next_turn,
    output logic                  reveal_en,
    output logic [COMBO_W-1:0]    combo_cnt,
    output logic [NUM_TILES-1:0]  flipped_mask,
    output logic                  sel_err,
    output logic                  game_over
);

    localparam logic [TILE_W:0] NUM_TILES_V = (TILE_W + 1)'(NUM_TILES);

    state_t state, state_d;
    logic   go_lat, go_lat_d;
    logic   a_d, b_d, next_turn_d, sel_err_d;
    logic [TILE_W-1:0]    pos_d;
    logic [COMBO_W-1:0]   combo_d;
    logic [NUM_TILES-1:0] mask_d;
    logic   lat_load, lat_done, rev_load, rev_done;

    logic [15:0] mask_ext;
    logic [15:0] tile_onehot;

    assign mask_ext    = 16'(flipped_mask);
    assign tile_onehot = 16'(1) << sel_tile;

    // The same handshake window (strobe cycle plus RESP_LAT) serves CHECK and MOVE.
    reveal_timer #(.CYCLES(RESP_LAT + 1)) u_lat_timer (
        .clk  (clk),
        .rst  (rst),
        .load (lat_load),
        .done (lat_done)
    );

    reveal_timer #(.CYCLES(REVEAL_CYCLES)) u_reveal_timer (
        .clk  (clk),
        .rst  (rst),
        .load (rev_load),
        .done (rev_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            go_lat               <= 1'b0;
            A                    <= 1'b0;
            B                    <= 1'b0;
            statecombo_next_turn <= 1'b0;
            reveal_en            <= 1'b0;
            sel_err              <= 1'b0;
            game_over            <= 1'b0;
            combo_cnt            <= '0;
            flipped_mask         <= '0;
            position_data        <= '0;
        end else begin
            state                <= state_d;
            go_lat               <= go_lat_d;
            A                    <= a_d;
            B                    <= b_d;
            statecombo_next_turn <= next_turn_d;
            reveal_en            <= (state_d == ST_REVEAL);
            sel_err              <= sel_err_d;
            game_over            <= (state_d == ST_WIN);
            combo_cnt            <= combo_d;
            flipped_mask         <= mask_d;
            position_data        <= pos_d;
        end
    end

    always_comb begin
        state_d     = state;
        go_lat_d    = go_lat;
        a_d         = 1'b0;
        b_d         = 1'b0;
        next_turn_d = 1'b0;
        sel_err_d   = 1'b0;
        pos_d       = position_data;
        combo_d     = combo_cnt;
        mask_d      = flipped_mask;
        lat_load    = 1'b0;
        rev_load    = 1'b0;

        case (state)
            ST_IDLE, ST_WIN: begin
                if (start) begin
                    state_d = ST_SELECT;
                    combo_d = '0;
                    mask_d  = '0;
                end
            end
            ST_SELECT: begin
                if (sel_valid) begin
                    if (({1'b0, sel_tile} >= NUM_TILES_V) || mask_ext[sel_tile]) begin
                        sel_err_d = 1'b1;
                    end else begin
                        a_d      = 1'b1;
                        pos_d    = sel_tile;
                        mask_d   = flipped_mask | tile_onehot[NUM_TILES-1:0];
                        state_d  = ST_CHECK;
                        lat_load = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (lat_done) begin
                    go_lat_d = go;
                    state_d  = ST_REVEAL;
                    rev_load = 1'b1;
                end
            end
            ST_REVEAL: begin
                if (rev_done) begin
                    if (go_lat) begin
                        state_d  = ST_MOVE;
                        b_d      = 1'b1;
                        lat_load = 1'b1;
                    end else begin
                        state_d     = ST_ENDTURN;
                        next_turn_d = 1'b1;
                        mask_d      = '0;
                        combo_d     = '0;
                    end
                end
            end
            ST_MOVE: begin
                if (lat_done) begin
                    if (W) begin
                        state_d = ST_WIN;
                    end else if (flipped_mask == {NUM_TILES{1'b1}}) begin
                        // Board exhausted: the incremented combo is cleared by the turn end anyway.
                        state_d     = ST_ENDTURN;
                        next_turn_d = 1'b1;
                        mask_d      = '0;
                        combo_d     = '0;
                    end else begin
                        state_d = ST_SELECT;
                        combo_d = (combo_cnt == COMBO_MAX) ? combo_cnt : combo_cnt + 1'b1;
                    end
                end
            end
            ST_ENDTURN: begin
                state_d = ST_SELECT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
